// File: rtl/tx_channel_router.sv
// Routes fixed-length 32-bit packets from the USB packer to one of NUM_CHAN data
// RAMs or the command RAM, dropping packets with a bad channel or no room.
module tx_channel_router #(
  parameter int unsigned NUM_CHAN    = 2,
  parameter int unsigned PKT_WORDS   = 128,
  parameter int unsigned CHAN_LSB    = 16,
  parameter logic [4:0]  CMD_CHAN_ID = 5'h1F,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                txclk,
  input  logic                reset,
  input  logic [31:0]         usbdata_final,
  input  logic                WR_final,
  input  logic [NUM_CHAN:0]   chan_have_space,
  input  logic                clear_status,
  output logic [NUM_CHAN:0]   WR_channel,
  output logic [NUM_CHAN:0]   WR_done_channel,
  output logic [31:0]         ram_data,
  output logic                busy,
  output logic [CNT_W-1:0]    drop_count,
  output logic                drop_nospace,
  output logic                drop_badchan
);

  localparam int unsigned NCH    = NUM_CHAN + 1;
  localparam int unsigned DEST_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned WCNT_W = $clog2(PKT_WORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PKT_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic [DEST_W-1:0] dest, dest_nxt;
  logic [NCH-1:0]    done_pend, done_pend_nxt;
  logic [NCH-1:0]    wr_nxt, done_nxt;
  logic [31:0]       data_nxt;
  logic              busy_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              nospace_nxt, badchan_nxt;
  logic              drop_bad, drop_nos, drop_any;

  logic [4:0]        hdr_ch;
  logic              hdr_valid;
  logic [DEST_W-1:0] hdr_dest;

  // Header channel decode; command channel takes priority over the data range.
  always_comb begin
    hdr_ch    = usbdata_final[CHAN_LSB+4:CHAN_LSB];
    hdr_valid = 1'b0;
    hdr_dest  = '0;
    if (hdr_ch == CMD_CHAN_ID) begin
      hdr_valid = 1'b1;
      hdr_dest  = DEST_W'(NUM_CHAN);
    end else if (32'(hdr_ch) < NUM_CHAN) begin
      hdr_valid = 1'b1;
      hdr_dest  = DEST_W'(hdr_ch);
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    dest_nxt      = dest;
    wr_nxt        = '0;
    done_pend_nxt = '0;
    done_nxt      = done_pend;
    data_nxt      = ram_data;
    drop_bad      = 1'b0;
    drop_nos      = 1'b0;

    case (state)
      S_IDLE: begin
        if (WR_final) begin
          wcnt_nxt = WCNT_W'(1);
          dest_nxt = hdr_dest;
          if (!hdr_valid) begin
            state_nxt = S_DROP;
            drop_bad  = 1'b1;
          end else if (!chan_have_space[hdr_dest]) begin
            state_nxt = S_DROP;
            drop_nos  = 1'b1;
          end else begin
            state_nxt = S_FWD;
            wr_nxt    = NCH'(1) << hdr_dest;
            data_nxt  = usbdata_final;
          end
        end
      end
      S_FWD: begin
        if (WR_final) begin
          wr_nxt   = NCH'(1) << dest;
          data_nxt = usbdata_final;
          if (wcnt == LAST_WORD) begin
            state_nxt     = S_IDLE;
            wcnt_nxt      = '0;
            done_pend_nxt = NCH'(1) << dest;
          end else begin
            wcnt_nxt = wcnt + WCNT_W'(1);
          end
        end
      end
      S_DROP: begin
        if (WR_final) begin
          if (wcnt == LAST_WORD) begin
            state_nxt = S_IDLE;
            wcnt_nxt  = '0;
          end else begin
            wcnt_nxt = wcnt + WCNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        wcnt_nxt  = '0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
    drop_any = drop_bad | drop_nos;

    // A drop coinciding with clear survives as a fresh count of one.
    if (clear_status) begin
      cnt_nxt     = drop_any ? CNT_W'(1) : '0;
      nospace_nxt = drop_nos;
      badchan_nxt = drop_bad;
    end else begin
      cnt_nxt     = (drop_any && (drop_count != '1)) ? drop_count + CNT_W'(1) : drop_count;
      nospace_nxt = drop_nospace | drop_nos;
      badchan_nxt = drop_badchan | drop_bad;
    end
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      state           <= S_IDLE;
      wcnt            <= '0;
      dest            <= '0;
      done_pend       <= '0;
      WR_channel      <= '0;
      WR_done_channel <= '0;
      ram_data        <= '0;
      busy            <= 1'b0;
      drop_count      <= '0;
      drop_nospace    <= 1'b0;
      drop_badchan    <= 1'b0;
    end else begin
      state           <= state_nxt;
      wcnt            <= wcnt_nxt;
      dest            <= dest_nxt;
      done_pend       <= done_pend_nxt;
      WR_channel      <= wr_nxt;
      WR_done_channel <= done_nxt;
      ram_data        <= data_nxt;
      busy            <= busy_nxt;
      drop_count      <= cnt_nxt;
      drop_nospace    <= nospace_nxt;
      drop_badchan    <= badchan_nxt;
    end
  end

endmodule
